// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder for the core's
// load/store/fetch traffic. A request is accepted in IDLE, held for LATENCY
// cycles in WAIT, then resolved on the edge that enters RESP. That edge
// performs the range check, commits any write and captures the response.
// The response is held until the initiator takes it.

module mem_responder #(
   parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
   parameter int          DEPTH_WORDS = 4096,
   parameter int          LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [63:0] LIMIT_ADDR = BASE_ADDR + 64'(DEPTH_WORDS) * 64'd8;
   localparam logic [3:0]  LAT_INIT   = 4'(LATENCY);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  waitCnt_q, waitCnt_d;
   logic        accept;
   logic        enterResp;

   logic        reqWe_q;
   logic [63:0] reqAddr_q;
   logic [63:0] reqWdata_q;
   logic [7:0]  reqWstrb_q;

   logic [63:0] rspRdata_q;
   logic        rspErr_q;

   logic [63:0] mem [DEPTH_WORDS];

   logic        srcWe;
   logic [63:0] srcAddr;
   logic [63:0] srcWdata;
   logic [7:0]  srcWstrb;
   logic [63:0] wordOffset;
   logic [IDX_W-1:0] wordIdx;
   logic        inRange;
   logic        unusedOffsetBits;

   // With zero latency, RESP is entered on the accept edge itself, so the
   // live request inputs are used. Otherwise the latched copy is used.
   always_comb begin
      if (state_q == IDLE) begin
         srcWe    = req_we;
         srcAddr  = req_addr;
         srcWdata = req_wdata;
         srcWstrb = req_wstrb;
      end else begin
         srcWe    = reqWe_q;
         srcAddr  = reqAddr_q;
         srcWdata = reqWdata_q;
         srcWstrb = reqWstrb_q;
      end
   end

   assign inRange          = (srcAddr >= BASE_ADDR) && (srcAddr < LIMIT_ADDR);
   assign wordOffset       = srcAddr - BASE_ADDR;
   assign wordIdx          = wordOffset[IDX_W+2:3];
   assign unusedOffsetBits = ^{wordOffset[63:IDX_W+3], wordOffset[2:0]};

   // Next-state logic: accept in IDLE, count down in WAIT, and leave RESP on the handshake.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      accept    = 1'b0;
      enterResp = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               if (LATENCY == 0) begin
                  state_d   = RESP;
                  enterResp = 1'b1;
               end else begin
                  state_d   = WAIT;
                  waitCnt_d = LAT_INIT;
               end
            end
         end
         WAIT: begin
            waitCnt_d = waitCnt_q - 4'd1;
            if (waitCnt_q == 4'd1) begin
               state_d   = RESP;
               waitCnt_d = 4'd0;
               enterResp = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register, wait counter and latched request. All are cleared on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         waitCnt_q  <= 4'd0;
         reqWe_q    <= 1'b0;
         reqAddr_q  <= 64'd0;
         reqWdata_q <= 64'd0;
         reqWstrb_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         if (accept) begin
            reqWe_q    <= req_we;
            reqAddr_q  <= req_addr;
            reqWdata_q <= req_wdata;
            reqWstrb_q <= req_wstrb;
         end
      end
   end

   // Byte-strobed commit on RESP entry. The array is not reset. The rst
   // term keeps a write from landing while reset is held.
   always_ff @(posedge clk) begin
      if (rst && enterResp && inRange && srcWe) begin
         for (int i = 0; i < 8; i++) begin
            if (srcWstrb[i]) begin
               mem[wordIdx][8*i +: 8] <= srcWdata[8*i +: 8];
            end
         end
      end
   end

   // Response capture on RESP entry. Read data comes only from in-range
   // reads. The captured values are held through any backpressure.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rspRdata_q <= 64'd0;
         rspErr_q   <= 1'b0;
      end else if (enterResp) begin
         rspErr_q   <= !inRange;
         rspRdata_q <= (inRange && !srcWe) ? mem[wordIdx] : 64'd0;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rspRdata_q;
   assign rsp_err   = rspErr_q;

endmodule
